csr_bank: RTL

// - Register bank downstream of the serial CSR protocol engine; consumes its addr/write/data strobes, returns read data + ready.
// - Holds ID, scratch, control/status, 16-bit event counter with atomic snapshot, LED output register.
// - Single clock domain. Request/response: one request in flight; response after fixed programmable delay.

---
 rtl/csr_bank_pkg.sv | 27 ++
 rtl/csr_snapcnt.sv | 49 ++++
 rtl/csr_bank.sv | 132 +++++++++++++
 3 files changed

// File: rtl/csr_bank_pkg.sv
// Shared register map, CTRL/STATUS bit positions and request FSM encoding for csr_bank.
package csr_bank_pkg;

    localparam logic [6:0] ADR_ID      = 7'h00;
    localparam logic [6:0] ADR_SCRATCH = 7'h01;
    localparam logic [6:0] ADR_CTRL    = 7'h02;
    localparam logic [6:0] ADR_STATUS  = 7'h03;
    localparam logic [6:0] ADR_CNT_LO  = 7'h04;
    localparam logic [6:0] ADR_CNT_HI  = 7'h05;
    localparam logic [6:0] ADR_LED     = 7'h06;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    localparam int ST_WRAP  = 0;
    localparam int ST_UNMAP = 1;
    localparam int ST_OVR   = 2;

    localparam logic [1:0] FSM_IDLE = 2'd0;
    localparam logic [1:0] FSM_WAIT = 2'd1;
    localparam logic [1:0] FSM_RESP = 2'd2;

    function automatic logic is_mapped(input logic [6:0] adr);
        return adr <= ADR_LED;
    endfunction

endpackage

// File: rtl/csr_snapcnt.sv
// Event counter with sync clear (dominant over increment), wrap pulse, and a
// snapshot of the high byte taken whenever the low byte is read.
module csr_snapcnt #(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       inc,
    input  logic       clr,
    input  logic       snap,
    output logic [7:0] cnt_lo,
    output logic [7:0] snap_hi,
    output logic       wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       snap_q, snap_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap   = 1'b0;
        snap_d = snap_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && inc) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            wrap  = &cnt_q;
        end
        // Snapshot uses the pre-edge value so LO and HI describe the same count.
        if (snap) begin
            snap_d = cnt_q[15:8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end

    assign cnt_lo  = cnt_q[7:0];
    assign snap_hi = snap_q;

endmodule

// File: rtl/csr_bank.sv
// CSR register bank: one request in flight, response RESP_DELAY cycles after acceptance.
// Side effects and read data are captured on the accepting edge; requests while busy are dropped.
module csr_bank
    import csr_bank_pkg::*;
#(
    parameter logic [7:0] ID_VALUE   = 8'hA5,
    parameter int         RESP_DELAY = 1,
    parameter int         CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       csr_req,
    input  logic       csr_we,
    input  logic [6:0] csr_adr,
    input  logic [7:0] csr_dat_in,
    input  logic       event_in,
    output logic [7:0] csr_dat_out,
    output logic       csr_ready,
    output logic [7:0] led
);

    localparam logic [3:0] DLY_LOAD = 4'(RESP_DELAY - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] dly_q, dly_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] scratch_q, scratch_d;
    logic       ctrl_en_q, ctrl_en_d;
    logic [2:0] status_q, status_d;
    logic [7:0] led_q, led_d;

    logic       accept, wr;
    logic       cnt_clr, cnt_snap, cnt_wrap;
    logic [7:0] cnt_lo, snap_hi;
    logic [7:0] rd_val;
    logic [2:0] st_set, st_clr;

    csr_snapcnt #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (ctrl_en_q),
        .inc     (event_in),
        .clr     (cnt_clr),
        .snap    (cnt_snap),
        .cnt_lo  (cnt_lo),
        .snap_hi (snap_hi),
        .wrap    (cnt_wrap)
    );

    always_comb begin
        accept   = csr_req && (state_q == FSM_IDLE);
        wr       = accept && csr_we;
        cnt_clr  = wr && (csr_adr == ADR_CTRL) && csr_dat_in[CTRL_CLR];
        cnt_snap = accept && !csr_we && (csr_adr == ADR_CNT_LO);

        case (csr_adr)
            ADR_ID:      rd_val = ID_VALUE;
            ADR_SCRATCH: rd_val = scratch_q;
            ADR_CTRL:    rd_val = {7'b0, ctrl_en_q};
            ADR_STATUS:  rd_val = {5'b0, status_q};
            ADR_CNT_LO:  rd_val = cnt_lo;
            ADR_CNT_HI:  rd_val = snap_hi;
            ADR_LED:     rd_val = led_q;
            default:     rd_val = 8'h00;
        endcase

        scratch_d = scratch_q;
        ctrl_en_d = ctrl_en_q;
        led_d     = led_q;
        if (wr) begin
            case (csr_adr)
                ADR_SCRATCH: scratch_d = csr_dat_in;
                ADR_CTRL:    ctrl_en_d = csr_dat_in[CTRL_EN];
                ADR_LED:     led_d     = csr_dat_in;
                default:     ;
            endcase
        end

        // Set has priority over W1C so an event landing on the clearing write survives.
        st_set           = '0;
        st_set[ST_WRAP]  = cnt_wrap;
        st_set[ST_UNMAP] = accept && !is_mapped(csr_adr);
        st_set[ST_OVR]   = csr_req && (state_q != FSM_IDLE);
        st_clr           = (wr && (csr_adr == ADR_STATUS)) ? csr_dat_in[2:0] : 3'b000;
        status_d         = (status_q & ~st_clr) | st_set;

        rdata_d = rdata_q;
        if (accept) begin
            rdata_d = csr_we ? csr_dat_in : rd_val;
        end

        state_d = state_q;
        dly_d   = dly_q;
        case (state_q)
            FSM_IDLE: if (accept) begin
                dly_d   = DLY_LOAD;
                state_d = (DLY_LOAD == 4'd0) ? FSM_RESP : FSM_WAIT;
            end
            FSM_WAIT: begin
                dly_d = dly_q - 4'd1;
                if (dly_q == 4'd1) state_d = FSM_RESP;
            end
            FSM_RESP: state_d = FSM_IDLE;
            default:  state_d = FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FSM_IDLE;
            dly_q     <= '0;
            rdata_q   <= '0;
            scratch_q <= '0;
            ctrl_en_q <= 1'b0;
            status_q  <= '0;
            led_q     <= '0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            rdata_q   <= rdata_d;
            scratch_q <= scratch_d;
            ctrl_en_q <= ctrl_en_d;
            status_q  <= status_d;
            led_q     <= led_d;
        end
    end

    assign csr_ready   = (state_q == FSM_RESP);
    assign csr_dat_out = csr_ready ? rdata_q : 8'h00;
    assign led         = led_q;

endmodule
